// File: rtl/demux_2d_buf_if.sv
// Purpose: handshake bundle for the buffered 1-to-2 demux (one input stream, two output channels).
// Ports:   din/din_sel/din_valid/din_ready on the input side; doutX/doutX_valid/doutX_ready per channel.
// master = producer of din and consumer of dout0/dout1; slave = the demux itself.
interface demux_2d_buf_if #(
    parameter int w = 32
);
    logic [w-1:0] din;
    logic         din_sel;
    logic         din_valid;
    logic         din_ready;
    logic [w-1:0] dout0;
    logic         dout0_valid;
    logic         dout0_ready;
    logic [w-1:0] dout1;
    logic         dout1_valid;
    logic         dout1_ready;

    modport master (
        output din, din_sel, din_valid, dout0_ready, dout1_ready,
        input  din_ready, dout0, dout0_valid, dout1, dout1_valid
    );

    modport slave (
        input  din, din_sel, din_valid, dout0_ready, dout1_ready,
        output din_ready, dout0, dout0_valid, dout1, dout1_valid
    );
endinterface

// File: rtl/demux_2d_buf.sv
// Purpose: buffered 1-to-2 demux; din is steered by din_sel into one of two d-deep FIFO channels.
// Latency: one edge from enqueue to doutX_valid on an empty channel; dout is mem[rd_ptr], no din->dout path.
// Backpressure: din_ready = ~full of the selected channel only; a full channel refuses even while it dequeues.
// Ports: clk, rst_n (async active low), bus (demux_2d_buf_if.slave), and cnt0/cnt1 (16-bit saturating
// delivered-word counters) present only when the macro DEMUX_2D_CNT_EN is defined.
// Parameters: w = data width, d = entries per channel (power of 2, >= 2).

// Generic single-clock FIFO used once per channel.
// Latency: a write appears on rd_dat/rd_vld after the writing edge; read data is the stored head word.
// Backpressure: writes are dropped while full (caller gates on ~full); reads ignored while empty.
module demux_2d_buf_fifo #(
    parameter int w = 32,
    parameter int d = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [w-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [w-1:0] rd_dat
);
    localparam int aw = $clog2(d);

    logic [w-1:0]  mem [d];
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr;
    logic [aw:0]   count;
    logic          push;
    logic          pop;

    assign full   = (count == (aw+1)'(d));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    // A full FIFO never accepts a write, even when it is being read in the same cycle.
    assign push = wr_vld & ~full;
    assign pop  = rd_vld & rd_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < d; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                // d is a power of 2, so natural overflow gives the mod-d wrap.
                wr_ptr      <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (aw+1)'(1);
                2'b01:   count <= count - (aw+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module demux_2d_buf #(
    parameter int w = 32,
    parameter int d = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_2d_buf_if.slave        bus
`ifdef DEMUX_2D_CNT_EN
    ,
    output logic [15:0]          cnt0,
    output logic [15:0]          cnt1
`endif
);
    logic full0;
    logic full1;

    // Ready looks only at the selected channel's fullness, never at din_valid or doutX_ready.
    assign bus.din_ready = bus.din_sel ? ~full1 : ~full0;

    demux_2d_buf_fifo #(.w(w), .d(d)) u_ch0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (bus.din_valid & ~bus.din_sel),
        .wr_dat (bus.din),
        .full   (full0),
        .rd_vld (bus.dout0_valid),
        .rd_rdy (bus.dout0_ready),
        .rd_dat (bus.dout0)
    );

    demux_2d_buf_fifo #(.w(w), .d(d)) u_ch1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (bus.din_valid & bus.din_sel),
        .wr_dat (bus.din),
        .full   (full1),
        .rd_vld (bus.dout1_valid),
        .rd_rdy (bus.dout1_ready),
        .rd_dat (bus.dout1)
    );

`ifdef DEMUX_2D_CNT_EN
    // Delivered-word counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (bus.dout0_valid && bus.dout0_ready && cnt0 != 16'hFFFF) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (bus.dout1_valid && bus.dout1_ready && cnt1 != 16'hFFFF) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_demux_2d_buf.sv
// Bench for demux_2d_buf (w=32, d=2): queue scoreboard per channel, expected words pushed on
// accepted enqueues and compared/popped as the DUT delivers; inputs change on the falling edge.
module tb_demux_2d_buf;
    localparam int W = 32;
    localparam int D = 2;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [15:0]  cnt0_exp;
    logic [15:0]  cnt1_exp;

    demux_2d_buf_if #(.w(W)) bus ();

`ifdef DEMUX_2D_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    demux_2d_buf #(.w(W), .d(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .cnt0(cnt0), .cnt1(cnt1));
`else
    demux_2d_buf #(.w(W), .d(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already set: checks outputs against the
    // scoreboard, then advances the model across the next rising edge.
    task automatic cyc();
        logic en;
        logic de0;
        logic de1;
        logic rdy_exp;
        #1;
        rdy_exp = bus.din_sel ? (q1.size() < D) : (q0.size() < D);
        chk("din_ready", {31'b0, bus.din_ready}, {31'b0, rdy_exp});
        chk("dout0_valid", {31'b0, bus.dout0_valid}, {31'b0, q0.size() != 0});
        chk("dout1_valid", {31'b0, bus.dout1_valid}, {31'b0, q1.size() != 0});
        if (q0.size() != 0) chk("dout0", bus.dout0, q0[0]);
        if (q1.size() != 0) chk("dout1", bus.dout1, q1[0]);
`ifdef DEMUX_2D_CNT_EN
        chk("cnt0", {16'b0, cnt0}, {16'b0, cnt0_exp});
        chk("cnt1", {16'b0, cnt1}, {16'b0, cnt1_exp});
`endif
        en  = bus.din_valid && rdy_exp;
        de0 = bus.dout0_ready && (q0.size() != 0);
        de1 = bus.dout1_ready && (q1.size() != 0);
        @(posedge clk);
        if (de0) begin
            void'(q0.pop_front());
            if (cnt0_exp != 16'hFFFF) cnt0_exp++;
        end
        if (de1) begin
            void'(q1.pop_front());
            if (cnt1_exp != 16'hFFFF) cnt1_exp++;
        end
        if (en) begin
            if (bus.din_sel) q1.push_back(bus.din);
            else             q0.push_back(bus.din);
        end
        @(negedge clk);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        cnt0_exp = '0;
        cnt1_exp = '0;
    endtask

    task automatic idle_inputs();
        bus.din         = '0;
        bus.din_sel     = 1'b0;
        bus.din_valid   = 1'b0;
        bus.dout0_ready = 1'b0;
        bus.dout1_ready = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_v0"}, {31'b0, bus.dout0_valid}, 32'd0);
        chk({tag, "_v1"}, {31'b0, bus.dout1_valid}, 32'd0);
        chk({tag, "_d0"}, bus.dout0, 32'd0);
        chk({tag, "_d1"}, bus.dout1, 32'd0);
        chk({tag, "_rdy"}, {31'b0, bus.din_ready}, 32'd1);
`ifdef DEMUX_2D_CNT_EN
        chk({tag, "_c0"}, {16'b0, cnt0}, 32'd0);
        chk({tag, "_c1"}, {16'b0, cnt1}, 32'd0);
`endif
    endtask

    task automatic send(input logic sel, input logic [W-1:0] val);
        bus.din_sel   = sel;
        bus.din       = val;
        bus.din_valid = 1'b1;
        cyc();
        bus.din_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_clear();
        idle_inputs();
        rst_n = 1'b0;

        // 1. reset state
        repeat (3) @(negedge clk);
        #1 reset_checks("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 2. steering to ch1, latency and hold under backpressure
        send(1'b1, 32'hDEAD_BEEF);
        repeat (5) cyc();
        bus.dout1_ready = 1'b1;
        cyc();
        cyc();
        bus.dout1_ready = 1'b0;

        // 3. fill ch0, per-channel ready, pending word held while full
        send(1'b0, 32'd1);
        send(1'b0, 32'd2);
        bus.din_sel = 1'b0;
        cyc();
        bus.din_sel = 1'b1;
        cyc();
        bus.din_sel   = 1'b0;
        bus.din       = 32'd3;
        bus.din_valid = 1'b1;
        cyc();
        bus.dout0_ready = 1'b1;
        cyc();                       // full: dequeue 1 only, din_ready stays low
        cyc();                       // 3 accepted while 2 leaves
        bus.din_valid = 1'b0;
        repeat (3) cyc();
        chk("fill_drained", q0.size(), 32'd0);

        // 4. simultaneous enqueue/dequeue at count 1, pointers wrap repeatedly
        bus.dout0_ready = 1'b0;
        send(1'b0, 32'd9);
        bus.dout0_ready = 1'b1;
        for (int i = 10; i <= 17; i++) begin
            bus.din_sel   = 1'b0;
            bus.din       = i;
            bus.din_valid = 1'b1;
            cyc();
            chk("ee_count", q0.size(), 32'd1);
        end
        bus.din_valid = 1'b0;
        repeat (2) cyc();
        bus.dout0_ready = 1'b0;

        // 5. reset while both channels are full
        send(1'b0, 32'hA0);
        send(1'b0, 32'hA1);
        send(1'b1, 32'hB0);
        send(1'b1, 32'hB1);
        #1 chk("pre_rst_v0", {31'b0, bus.dout0_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1 reset_checks("midrst");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        bus.dout0_ready = 1'b1;
        bus.dout1_ready = 1'b1;
        send(1'b0, 32'h5);
        repeat (2) cyc();
        bus.dout0_ready = 1'b0;
        bus.dout1_ready = 1'b0;

`ifdef DEMUX_2D_CNT_EN
        // 6. counters: known dequeue counts from zero, then saturation on ch1
        rst_n = 1'b0;
        model_clear();
        #1 reset_checks("cntrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.dout0_ready = 1'b1;
        bus.dout1_ready = 1'b1;
        send(1'b0, 32'h31);
        send(1'b1, 32'h41);
        send(1'b0, 32'h32);
        send(1'b1, 32'h42);
        send(1'b0, 32'h33);
        cyc();
        chk("cnt0_three", {16'b0, cnt0}, 32'd3);
        chk("cnt1_two", {16'b0, cnt1}, 32'd2);
        bus.din_sel   = 1'b1;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            bus.din = i;
            cyc();
        end
        bus.din_valid = 1'b0;
        cyc();
        chk("cnt1_sat", {16'b0, cnt1}, 32'h0000_FFFF);
        chk("cnt0_hold", {16'b0, cnt0}, 32'd3);
        idle_inputs();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
